fb_port_arbiter: RTL and testbench

Owns the single port of the 640x480 RGB444 frame-buffer BRAM and shares it between the camera pixel writer and the display scan-out reader. Display reads always win. Camera writes are buffered in a small FIFO so short collisions lose nothing. The block also sequences freeze/snapshot: the current frame is completed, then camera writes are blocked, and writing resumes only at a frame boundary. The camera write stream arrives already in the `clk_reg` domain.

---
 rtl/fb_arb_pkg.sv | 24 ++
 rtl/fb_port_arbiter_if.sv | 39 +++
 rtl/fb_wr_fifo.sv | 66 ++++++
 rtl/fb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer port arbiter: default widths,
// frame size, freeze-sequencer states and the per-cycle port grant.
package fb_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 19;
    localparam int unsigned DEF_DATA_W     = 12;
    localparam int unsigned FRAME_PIXELS   = 307200;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_LIVE,
        ST_PENDING,
        ST_DRAIN,
        ST_FROZEN,
        ST_RESYNC
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } grant_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Camera write stream, display read port and BRAM port of the frame-buffer
// arbiter; slave is the arbiter side, master the client/memory side.
interface fb_port_arbiter_if #(
    parameter int unsigned ADDR_W = fb_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = fb_arb_pkg::DEF_DATA_W
);

    logic              cam_we;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;

    logic              disp_re;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cam_we, cam_addr, cam_data,
        input  disp_re, disp_addr,
        output disp_data, disp_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cam_we, cam_addr, cam_data,
        output disp_re, disp_addr,
        input  disp_data, disp_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for camera writes. Flags are
// registered; a push into a full FIFO succeeds when a pop happens alongside.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_reg,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop     = pop & ~empty;
        do_push    = push & (~full | do_pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (PTR_W + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_reg) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == (PTR_W + 1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk_reg) begin
        if (do_push) begin
            slots[wr_ptr] <= wdata;
        end
    end

    assign rdata = slots[rd_ptr];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads take priority over buffered
// camera writes, with a freeze/snapshot sequencer gating the camera stream.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W       = fb_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W       = fb_arb_pkg::DEF_DATA_W,
    parameter int unsigned FRAME_PIXELS = fb_arb_pkg::FRAME_PIXELS,
    parameter int unsigned FIFO_DEPTH   = fb_arb_pkg::DEF_FIFO_DEPTH
) (
    input  logic                   clk_reg,
    input  logic                   rst,
    fb_port_arbiter_if.slave       bus,
    input  logic                   freeze_req,
    input  logic                   unfreeze_req,
    output logic                   frozen,
    output logic [15:0]            ovf_cnt
);

    import fb_arb_pkg::*;

    localparam int unsigned       ENTRY_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    arb_state_e         state;
    arb_state_e         state_next;
    grant_e             grant;
    logic               wr_accept;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               drop;
    logic               is_last;
    logic               is_first;
    logic               freeze_only;
    logic               unfreeze_only;

    fb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_reg (clk_reg),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({bus.cam_addr, bus.cam_data}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_reg) begin
        if (rst) begin
            state <= ST_LIVE;
        end else begin
            state <= state_next;
        end
    end

    // Simultaneous freeze and unfreeze cancel each other out.
    always_comb begin
        is_last       = (bus.cam_addr == LAST_ADDR);
        is_first      = (bus.cam_addr == '0);
        freeze_only   = freeze_req & ~unfreeze_req;
        unfreeze_only = unfreeze_req & ~freeze_req;

        grant = GNT_IDLE;
        if (bus.disp_re) begin
            grant = GNT_READ;
        end else if (!fifo_empty) begin
            grant = GNT_WRITE;
        end
        fifo_pop = (grant == GNT_WRITE);

        wr_accept  = 1'b0;
        state_next = state;
        case (state)
            ST_LIVE: begin
                wr_accept = 1'b1;
                if (freeze_only) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                wr_accept = 1'b1;
                if (bus.cam_we && is_last) begin
                    state_next = ST_DRAIN;
                end else if (unfreeze_only) begin
                    state_next = ST_LIVE;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (unfreeze_only) begin
                    state_next = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (bus.cam_we && is_first) begin
                    wr_accept  = 1'b1;
                    state_next = ST_LIVE;
                end else if (freeze_only) begin
                    state_next = ST_FROZEN;
                end
            end
            default: begin
                state_next = ST_LIVE;
            end
        endcase

        fifo_push = bus.cam_we & wr_accept;
        drop      = fifo_push & fifo_full & ~fifo_pop;
    end

    // Address and write data hold their last value while the port is idle.
    always_ff @(posedge clk_reg) begin
        if (rst) begin
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.disp_valid <= 1'b0;
        end else begin
            case (grant)
                GNT_READ: begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= bus.disp_addr;
                    bus.mem_wdata <= '0;
                end
                GNT_WRITE: begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= fifo_rdata[ENTRY_W-1 -: ADDR_W];
                    bus.mem_wdata <= fifo_rdata[DATA_W-1:0];
                end
                default: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                end
            endcase
            bus.disp_valid <= bus.mem_en & ~bus.mem_we;
        end
    end

    // BRAM read data arrives one cycle after the read enable.
    always_comb begin
        bus.disp_data = bus.disp_valid ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk_reg) begin
        if (rst) begin
            ovf_cnt <= '0;
            frozen  <= 1'b0;
        end else begin
            if (drop && ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            frozen <= (state == ST_FROZEN);
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised and directed bench for fb_port_arbiter with a queue-based
// reference model and a scoreboard monitor on the BRAM and display ports.
module tb_fb_port_arbiter;

    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAST  = 307199;

    localparam int M_LIVE    = 0;
    localparam int M_PENDING = 1;
    localparam int M_DRAIN   = 2;
    localparam int M_FROZEN  = 3;
    localparam int M_RESYNC  = 4;

    logic        clk_reg = 1'b0;
    logic        rst = 1'b1;
    logic        freeze_req = 1'b0;
    logic        unfreeze_req = 1'b0;
    logic        frozen;
    logic [15:0] ovf_cnt;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .FRAME_PIXELS (307200),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_reg      (clk_reg),
        .rst          (rst),
        .bus          (bus),
        .freeze_req   (freeze_req),
        .unfreeze_req (unfreeze_req),
        .frozen       (frozen),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk_reg = ~clk_reg;

    // BRAM model: read data is address + 1, one cycle after the enable.
    always @(posedge clk_reg) begin
        if (bus.mem_en && !bus.mem_we) begin
            bus.mem_rdata <= DW'(bus.mem_addr + 1);
        end
    end

    typedef struct {
        int unsigned   tag;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    op_t         exp_mem[$];
    op_t         exp_rd[$];
    wr_t         pend[$];
    int          m_state = M_LIVE;
    bit          m_frozen = 1'b0;
    int unsigned m_ovf = 0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: port ownership and freeze sequencing from the rules.
    always @(posedge clk_reg) begin : model
        int  n0;
        bit  accepts;
        bit  frz;
        bit  unf;
        op_t o;
        wr_t w;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_mem.delete();
            exp_rd.delete();
            m_state  = M_LIVE;
            m_frozen = 1'b0;
            m_ovf    = 0;
        end else begin
            n0       = pend.size();
            m_frozen = (m_state == M_FROZEN);
            if (bus.disp_re) begin
                o = '{cyc, 1'b0, bus.disp_addr, '0};
                exp_mem.push_back(o);
                o.tag  = cyc + 1;
                o.data = DW'(bus.disp_addr + 1);
                exp_rd.push_back(o);
            end else if (n0 > 0) begin
                w = pend.pop_front();
                o = '{cyc, 1'b1, w.addr, w.data};
                exp_mem.push_back(o);
            end
            accepts = (m_state == M_LIVE) || (m_state == M_PENDING) ||
                      (m_state == M_RESYNC && bus.cam_addr == '0);
            if (bus.cam_we && accepts) begin
                if (pend.size() < DEPTH) begin
                    w = '{bus.cam_addr, bus.cam_data};
                    pend.push_back(w);
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
            end
            frz = freeze_req && !unfreeze_req;
            unf = unfreeze_req && !freeze_req;
            case (m_state)
                M_LIVE:    if (frz) m_state = M_PENDING;
                M_PENDING: begin
                    if (bus.cam_we && bus.cam_addr == LAST) m_state = M_DRAIN;
                    else if (unf) m_state = M_LIVE;
                end
                M_DRAIN:   if (n0 == 0) m_state = M_FROZEN;
                M_FROZEN:  if (unf) m_state = M_RESYNC;
                default: begin
                    if (bus.cam_we && bus.cam_addr == '0) m_state = M_LIVE;
                    else if (frz) m_state = M_FROZEN;
                end
            endcase
        end
    end

    // Monitor: every DUT port event is matched against the expected queues.
    always @(negedge clk_reg) begin : monitor
        op_t o;
        if (cyc > 0) begin
            while (exp_mem.size() > 0 && exp_mem[0].tag < cyc) begin
                o = exp_mem.pop_front();
                total++;
                bad++;
                $display("FAIL mem_op_missing: got none expected we=%0d addr=%0d at cycle %0d", o.we, o.addr, o.tag);
            end
            if (bus.mem_en) begin
                if (exp_mem.size() == 0 || exp_mem[0].tag != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL mem_op_unexpected: got we=%0d addr=%0d expected none (cycle %0d)", bus.mem_we, bus.mem_addr, cyc);
                end else begin
                    o = exp_mem.pop_front();
                    chk("mem_we", 64'(bus.mem_we), 64'(o.we));
                    chk("mem_addr", 64'(bus.mem_addr), 64'(o.addr));
                    if (o.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(o.data));
                end
            end
            while (exp_rd.size() > 0 && exp_rd[0].tag < cyc) begin
                o = exp_rd.pop_front();
                total++;
                bad++;
                $display("FAIL disp_valid_missing: got none expected data=%0h at cycle %0d", o.data, o.tag);
            end
            if (bus.disp_valid) begin
                if (exp_rd.size() == 0 || exp_rd[0].tag != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL disp_valid_unexpected: got data=%0h expected none (cycle %0d)", bus.disp_data, cyc);
                end else begin
                    o = exp_rd.pop_front();
                    chk("disp_data", 64'(bus.disp_data), 64'(o.data));
                end
            end
            chk("frozen", 64'(frozen), 64'(m_frozen));
            chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        end
    end

    task automatic step(input bit re, input logic [AW-1:0] ra, input bit we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit frz, input bit unf);
        bus.disp_re   = re;
        bus.disp_addr = ra;
        bus.cam_we    = we;
        bus.cam_addr  = wa;
        bus.cam_data  = wd;
        freeze_req    = frz;
        unfreeze_req  = unf;
        @(negedge clk_reg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return AW'(LAST);
        if (r == 2) return AW'(LAST - 1);
        return AW'($urandom_range(1, LAST - 2));
    endfunction

    initial begin
        bus.disp_re   = 1'b0;
        bus.disp_addr = '0;
        bus.cam_we    = 1'b0;
        bus.cam_addr  = '0;
        bus.cam_data  = '0;
        bus.mem_rdata = '0;
        rst = 1'b1;
        @(negedge clk_reg);
        idle(2);
        chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
        chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'(0));
        chk("rst_disp_data", 64'(bus.disp_data), 64'(0));
        chk("rst_frozen", 64'(frozen), 64'(0));
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
        rst = 1'b0;

        step(1'b0, '0, 1'b1, 19'd5, 12'hABC, 1'b0, 1'b0);
        idle(4);

        step(1'b1, 19'd10, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 19'd11, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 19'd12, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 8; i++)
            step(1'b1, AW'(100 + i), (i % 2 == 0), AW'(200 + i), DW'(12'h100 + i), 1'b0, 1'b0);
        idle(8);
        chk("ovf_after_4_writes", 64'(ovf_cnt), 64'(0));

        for (int i = 0; i < 8; i++)
            step(1'b1, AW'(300 + i), (i < 6), AW'(400 + i), DW'(12'h200 + i), 1'b0, 1'b0);
        idle(8);
        chk("ovf_after_6_writes", 64'(ovf_cnt), 64'(2));

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 4, AW'($urandom_range(0, LAST)),
                 $urandom_range(0, 9) < 6, pick_addr(), DW'($urandom),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++)
            step(i % 4 == 3, AW'(50 + i), 1'b1,
                 (i < 10) ? AW'(LAST - 9 + i) : AW'(i - 10), DW'($urandom), 1'b0, 1'b0);
        idle(12);
        chk("frozen_after_drain", 64'(frozen), 64'(1));

        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        idle(3);
        chk("frozen_after_both_req", 64'(frozen), 64'(1));

        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, AW'(LAST - 1), 12'h111, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, AW'(LAST), 12'h222, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 19'd0, 12'h333, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 19'd1, 12'h444, 1'b0, 1'b0);
        idle(5);
        chk("frozen_after_resume", 64'(frozen), 64'(0));

        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 19'd20, 1'b1, AW'(LAST - 2), 12'h555, 1'b0, 1'b0);
        step(1'b1, 19'd21, 1'b1, AW'(LAST - 1), 12'h666, 1'b0, 1'b0);
        step(1'b1, 19'd22, 1'b1, AW'(LAST), 12'h777, 1'b0, 1'b0);
        step(1'b1, 19'd23, 1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);
        chk("ovf_after_drain_reset", 64'(ovf_cnt), 64'(0));
        step(1'b0, '0, 1'b1, 19'd9, 12'h999, 1'b0, 1'b0);
        idle(6);

        chk("exp_mem_left", 64'(exp_mem.size()), 64'(0));
        chk("exp_rd_left", 64'(exp_rd.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
